// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch front end. It requests words from instruction memory one
//   at a time, buffers up to two fetched {instr, pc} entries in FIFO order, and
//   presents the head entry to the controller. A redirect (PCSrc) flushes the
//   buffer, retargets the fetch PC and squashes any in-flight response.
//
//   Optional feature (macro FETCH_PERF_EN): adds a 16-bit saturating count of
//   redirect cycles on output flush_count. Default build leaves it out.
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   imem_req     : read request, held high until imem_ack
//   imem_addr    : word-aligned read address, stable while imem_req=1
//   imem_ack     : response valid, completes the outstanding request
//   imem_rdata   : instruction word, valid with imem_ack
//   Instr        : head instruction (zero when InstrValid=0)
//   InstrPC      : address of Instr (zero when InstrValid=0)
//   InstrValid   : head entry valid
//   InstrReady   : consumer accepts the head entry this cycle
//   PCSrc        : redirect request from the controller
//   BranchTarget : redirect address, sampled when PCSrc=1
//   flush_count  : (FETCH_PERF_EN only) saturating redirect-cycle count
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] Instr,
  output logic [DATA_W-1:0] InstrPC,
  output logic              InstrValid,
  input  logic              InstrReady,
  input  logic              PCSrc,
  input  logic [DATA_W-1:0] BranchTarget
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       flush_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT        = 2'd1,
    S_WAIT_SQUASH = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        count;
  logic [DATA_W-1:0] fpc;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] head_instr, head_pc;
  logic [DATA_W-1:0] tail_instr, tail_pc;
  logic              push, consume, issue;
  logic              unused_target_lsbs;

  // Target LSBs are forced to zero on redirect, so they are never read.
  assign unused_target_lsbs = ^BranchTarget[1:0];

  assign InstrValid = (count != 2'd0);
  assign consume    = InstrValid & InstrReady;
  // A response is only kept when it belongs to the live stream and no
  // redirect is happening in the same cycle.
  assign push       = (state == S_WAIT) & imem_ack & ~PCSrc;
  // In IDLE nothing is outstanding, so the slot budget is just the queue
  // occupancy after this cycle's consumption. A redirect cycle never issues:
  // fpc is being reloaded and the old value must not go out.
  assign issue      = (state == S_IDLE) & ~PCSrc &
                      ((count - {1'b0, consume}) < 2'd2);

  assign Instr   = InstrValid ? head_instr : '0;
  assign InstrPC = InstrValid ? head_pc    : '0;

  // ---- request FSM: state register ----
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---- request FSM: next-state logic ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:        if (issue) state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_ack)   state_nxt = S_IDLE;
        else if (PCSrc) state_nxt = S_WAIT_SQUASH;
      end
      S_WAIT_SQUASH: if (imem_ack) state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  // ---- request FSM: outputs ----
  always_comb begin
    imem_req  = (state != S_IDLE);
    imem_addr = addr_q;
  end

  // ---- fetch PC and request address ----
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc    <= '0;
      addr_q <= '0;
    end else begin
      if (PCSrc)      fpc <= {BranchTarget[DATA_W-1:2], 2'b00};
      else if (issue) fpc <= fpc + DATA_W'(4);
      if (issue)      addr_q <= fpc;
    end
  end

  // ---- queue occupancy ----
  always_ff @(posedge clk) begin
    if (reset || PCSrc) begin
      count <= 2'd0;
    end else begin
      unique case ({push, consume})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // ---- queue storage ----
  // Two-slot shift queue. Push with consume can only happen at count=1
  // (the single request slot keeps the queue from being full while a
  // response is pending), so the new entry lands straight at the head.
  // Stale slot contents are harmless: the outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push && (consume || count == 2'd0)) begin
      head_instr <= imem_rdata;
      head_pc    <= addr_q;
    end else if (consume) begin
      head_instr <= tail_instr;
      head_pc    <= tail_pc;
    end
    if (push && !consume && count == 2'd1) begin
      tail_instr <= imem_rdata;
      tail_pc    <= addr_q;
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)      flush_count <= 16'd0;
    else if (PCSrc) flush_count <= sat_inc16(flush_count);
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue. A small memory responder inside the step
//   task acknowledges each request one cycle after it appears (unless told not
//   to) and returns a fixed scramble of the address as the instruction word.
//   Issued request addresses and consumed head entries are logged so the
//   directed steps can compare them against hand-computed sequences.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        PCSrc;
  logic [31:0] BranchTarget;
`ifdef FETCH_PERF_EN
  logic [15:0] flush_count;
`endif

  fetch_queue dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .Instr        (Instr),
    .InstrPC      (InstrPC),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget)
`ifdef FETCH_PERF_EN
    ,
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int age   = 0;
  int n_req = 0;
  int n_con = 0;
  logic [31:0] req_log [32];
  logic [31:0] con_pc  [32];
  logic [31:0] con_ins [32];
  int          con_cyc [32];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    n_req = 0;
    n_con = 0;
    age   = 0;
    cycle = 0;
    for (int i = 0; i < 32; i++) begin
      req_log[i] = '0;
      con_pc[i]  = '0;
      con_ins[i] = '0;
      con_cyc[i] = 0;
    end
  endtask

  // One clock cycle: drive inputs, let the responder act, log, advance to
  // 1 time unit after the next rising edge.
  task automatic cyc(input logic rdy, input logic pcs, input logic [31:0] tgt,
                     input logic ack_en);
    InstrReady   = rdy;
    PCSrc        = pcs;
    BranchTarget = tgt;
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    if (imem_req) begin
      if (age == 0 && n_req < 32) begin
        req_log[n_req] = imem_addr;
        n_req++;
      end
      if (ack_en && age >= 1) begin
        imem_ack   = 1'b1;
        imem_rdata = mem(imem_addr);
        age        = 0;
      end else begin
        age++;
      end
    end
    if (InstrValid && rdy && n_con < 32) begin
      con_pc[n_con]  = InstrPC;
      con_ins[n_con] = Instr;
      con_cyc[n_con] = cycle;
      n_con++;
    end
    @(posedge clk);
    #1;
    cycle++;
    imem_ack = 1'b0;
    PCSrc    = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset        = 1'b1;
    InstrReady   = 1'b0;
    PCSrc        = 1'b0;
    BranchTarget = '0;
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_rst_req"},   {31'd0, imem_req},   32'd0);
    chk({tag, "_rst_addr"},  imem_addr,           32'd0);
    chk({tag, "_rst_valid"}, {31'd0, InstrValid}, 32'd0);
    chk({tag, "_rst_instr"}, Instr,               32'd0);
    chk({tag, "_rst_pc"},    InstrPC,             32'd0);
`ifdef FETCH_PERF_EN
    chk({tag, "_rst_flush"}, {16'd0, flush_count}, 32'd0);
`endif
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // Streaming fetch, consumer always ready.
    do_reset("s1");
    chk("s1_idle_first", {31'd0, imem_req}, 32'd0);
    repeat (13) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("s1_req0", req_log[0], 32'h0000_0000);
    chk("s1_req1", req_log[1], 32'h0000_0004);
    chk("s1_req2", req_log[2], 32'h0000_0008);
    chk("s1_req3", req_log[3], 32'h0000_000C);
    chk("s1_ncon", n_con, 4);
    chk("s1_pc0",  con_pc[0], 32'h0000_0000);
    chk("s1_pc1",  con_pc[1], 32'h0000_0004);
    chk("s1_pc2",  con_pc[2], 32'h0000_0008);
    chk("s1_ins2", con_ins[2], 32'h5A5A_0F07);
    chk("s1_cyc0", con_cyc[0], 3);
    chk("s1_gap1", con_cyc[1] - con_cyc[0], 3);
    chk("s1_gap2", con_cyc[2] - con_cyc[1], 3);

    // Back-pressure: only two entries fetched, then drained in order.
    do_reset("s2");
    repeat (10) cyc(1'b0, 1'b0, '0, 1'b1);
    chk("s2_nreq",  n_req, 2);
    chk("s2_req0",  req_log[0], 32'h0000_0000);
    chk("s2_req1",  req_log[1], 32'h0000_0004);
    chk("s2_reqlo", {31'd0, imem_req}, 32'd0);
    chk("s2_valid", {31'd0, InstrValid}, 32'd1);
    chk("s2_head",  InstrPC, 32'h0000_0000);
    repeat (10) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("s2_pc0",  con_pc[0], 32'h0000_0000);
    chk("s2_pc1",  con_pc[1], 32'h0000_0004);
    chk("s2_pc2",  con_pc[2], 32'h0000_0008);
    chk("s2_ins1", con_ins[1], 32'h5A5A_0F0B);
    chk("s2_gap",  con_cyc[1] - con_cyc[0], 1);

    // Redirect while the request to 0x8 is outstanding; late ack squashed.
    do_reset("s3");
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_addr == 32'h8) begin
        found = 1'b1;
        break;
      end
      cyc(1'b1, 1'b0, '0, 1'b1);
    end
    chk("s3_found_req8", {31'd0, found}, 32'd1);
    cyc(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    chk("s3_sq_req",   {31'd0, imem_req}, 32'd1);
    chk("s3_sq_addr",  imem_addr, 32'h0000_0008);
    chk("s3_sq_valid", {31'd0, InstrValid}, 32'd0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1);
    chk("s3_drop_valid", {31'd0, InstrValid}, 32'd0);
    chk("s3_drop_req",   {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("s3_tgt_req",  {31'd0, imem_req}, 32'd1);
    chk("s3_tgt_addr", imem_addr, 32'h0000_0100);
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("s3_new_valid", {31'd0, InstrValid}, 32'd1);
    chk("s3_new_pc",    InstrPC, 32'h0000_0100);
    chk("s3_new_ins",   Instr, 32'h5A5A_0E0F);

    // Redirect in the same cycle as ack and head accept.
    do_reset("s4");
    repeat (5) cyc(1'b0, 1'b0, '0, 1'b1);
    chk("s4_pre_valid", {31'd0, InstrValid}, 32'd1);
    chk("s4_pre_addr",  imem_addr, 32'h0000_0004);
    cyc(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    chk("s4_valid", {31'd0, InstrValid}, 32'd0);
    chk("s4_instr", Instr, 32'd0);
    chk("s4_pc",    InstrPC, 32'd0);
    chk("s4_req",   {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("s4_tgt_addr", imem_addr, 32'h0000_0200);
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("s4_new_pc", InstrPC, 32'h0000_0200);

    // fpc wrap, reached through a misaligned redirect target.
    do_reset("s5");
    cyc(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
    chk("s5_noissue", {31'd0, imem_req}, 32'd0);
    repeat (8) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("s5_req0", req_log[0], 32'hFFFF_FFFC);
    chk("s5_req1", req_log[1], 32'h0000_0000);
    chk("s5_pc0",  con_pc[0], 32'hFFFF_FFFC);
    chk("s5_pc1",  con_pc[1], 32'h0000_0000);

    // Reset with a request outstanding; a stray ack in IDLE is ignored.
    do_reset("s6");
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("s6_pending", {31'd0, imem_req}, 32'd1);
    reset = 1'b1;
    cyc(1'b0, 1'b0, '0, 1'b0);
    reset = 1'b0;
    chk("s6_abandon", {31'd0, imem_req}, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    chk("s6_ign_valid", {31'd0, InstrValid}, 32'd0);
    chk("s6_reissue",   imem_addr, 32'h0000_0000);

`ifdef FETCH_PERF_EN
    do_reset("s7");
    repeat (3) cyc(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    chk("s7_flush3", {16'd0, flush_count}, 32'd3);
    do_reset("s7b");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
